// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Round-robin arbiter for a common data bus (CDB). Up to NUM_REQ functional
// units present a (tag, data) result; one is granted per cycle through a
// combinational one-hot req_ready, and the granted result is broadcast on the
// registered cdb_* outputs one cycle later.
//
// Ports
//   clk          : clock, all state on the rising edge
//   rst          : asynchronous, active-high reset
//   en           : global enable; no grants while low
//   req_valid    : [NUM_REQ]          requester i holds a result
//   req_tag      : [NUM_REQ*TAG_W]    tag of requester i at [i*TAG_W +: TAG_W]
//   req_data     : [NUM_REQ*DATA_W]   value of requester i at [i*DATA_W +: DATA_W]
//   req_ready    : [NUM_REQ]          one-hot grant (combinational)
//   cdb_valid    : registered broadcast valid (one cycle per transfer)
//   cdb_tag      : registered broadcast tag (holds when idle)
//   cdb_data     : registered broadcast value (holds when idle)
//   cdb_src      : index of the requester that sourced the broadcast
//   grant_count  : [NUM_REQ*16] saturating per-requester transfer counters,
//                  present only when CDB_ARB_STATS_EN is defined
//
// Build option
//   CDB_ARB_STATS_EN : adds grant_count and its counters.
// -----------------------------------------------------------------------------
module cdb_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 4,
   parameter int DATA_W  = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        cdb_valid,
   output logic [TAG_W-1:0]            cdb_tag,
   output logic [DATA_W-1:0]           cdb_data,
   output logic [$clog2(NUM_REQ)-1:0]  cdb_src
`ifdef CDB_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]       grant_count
`endif
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic              cdb_valid_q, cdb_valid_d;
   logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
   logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
   logic [IDX_W-1:0]  cdb_src_q, cdb_src_d;

   logic              grant_found;
   logic [IDX_W-1:0]  grant_idx;
   logic [TAG_W-1:0]  grant_tag;
   logic [DATA_W-1:0] grant_data;
   int                scan_idx;

   // Scan from rr_ptr upward (mod NUM_REQ); the first valid requester wins.
   // rst is folded in so req_ready stays low for the whole reset period.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      grant_tag   = '0;
      grant_data  = '0;
      scan_idx    = 0;
      if (en && !rst) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!grant_found && req_valid[scan_idx]) begin
               grant_found = 1'b1;
               grant_idx   = IDX_W'(scan_idx);
               grant_tag   = req_tag[scan_idx*TAG_W +: TAG_W];
               grant_data  = req_data[scan_idx*DATA_W +: DATA_W];
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (grant_found) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   // A grant is always a transfer (ready is only raised on a valid request),
   // so the broadcast registers load directly from the winner.
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      cdb_valid_d = grant_found;
      cdb_tag_d   = cdb_tag_q;
      cdb_data_d  = cdb_data_q;
      cdb_src_d   = cdb_src_q;
      if (grant_found) begin
         rr_ptr_d   = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
         cdb_tag_d  = grant_tag;
         cdb_data_d = grant_data;
         cdb_src_d  = grant_idx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q    <= '0;
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_data_q  <= '0;
         cdb_src_q   <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_tag_q   <= cdb_tag_d;
         cdb_data_q  <= cdb_data_d;
         cdb_src_q   <= cdb_src_d;
      end
   end

   assign cdb_valid = cdb_valid_q;
   assign cdb_tag   = cdb_tag_q;
   assign cdb_data  = cdb_data_q;
   assign cdb_src   = cdb_src_q;

`ifdef CDB_ARB_STATS_EN
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      logic [15:0] count_q, count_d;

      // Saturates at 16'hFFFF rather than wrapping.
      always_comb begin
         count_d = count_q;
         if (req_ready[gi] && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            count_q <= '0;
         end else begin
            count_q <= count_d;
         end
      end

      assign grant_count[gi*16 +: 16] = count_q;
   end
`endif

endmodule
